// File: rtl/timer_pkg.sv
// Shared types and helpers for the ramen-timer control stage.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

    localparam int unsigned KEY_START = 0;
    localparam int unsigned KEY_CLEAR = 1;

    // Number of clock cycles in a period given in milliseconds.
    function automatic int unsigned cycles_from_ms(input int unsigned freq_khz,
                                                   input int unsigned ms);
        return freq_khz * ms;
    endfunction

endpackage

// File: rtl/timer_key_ctrl_if.sv
// Signal bundle between the timer key controller and the counter chain / board pins.
interface timer_key_ctrl_if;
    import timer_pkg::*;

    logic [1:0]   key_n;
    logic         timeup;
    logic         tick_1s;
    logic         clr_pulse;
    logic         run;
    logic         done;
    timer_state_e state;

    modport master (
        output key_n,
        output timeup,
        input  tick_1s,
        input  clr_pulse,
        input  run,
        input  done,
        input  state
    );

    modport slave (
        input  key_n,
        input  timeup,
        output tick_1s,
        output clr_pulse,
        output run,
        output done,
        output state
    );

endinterface

// File: rtl/key_debounce.sv
// One push button: 2-FF synchroniser, counting debouncer and registered press (falling-edge) pulse.
module key_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_db,
    output logic press
);
    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             db_prev;
    logic [CNT_W-1:0] db_cnt;

    // A change is accepted only after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            key_db  <= 1'b1;
            db_prev <= 1'b1;
            db_cnt  <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            db_prev <= key_db;
            press   <= db_prev & ~key_db;
            if (sync2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
                key_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/timer_key_ctrl.sv
// Ramen-timer control: debounced start/pause and clear keys, run FSM, gated 1 s tick and clear pulse.
// Build option: define TIMER_LONGPRESS_CLR_EN to make key 1 clear only on a long hold.
module timer_key_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_KHZ = 50000,
    parameter int unsigned DEBOUNCE_MS  = 10,
    parameter int unsigned LONGPRESS_MS = 2000
) (
    input logic             clk,
    input logic             rst_n,
    timer_key_ctrl_if.slave bus
);
    localparam int unsigned SEC_CYCLES = cycles_from_ms(CLK_FREQ_KHZ, 1000);
    localparam int unsigned DB_CYCLES  = cycles_from_ms(CLK_FREQ_KHZ, DEBOUNCE_MS);
    localparam int unsigned LP_CYCLES  = cycles_from_ms(CLK_FREQ_KHZ, LONGPRESS_MS);
    localparam int unsigned PRE_W      = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

    logic [1:0]       key_db;
    logic [1:0]       press;
    logic             start_ev;
    logic             clr_ev;
    logic             unused_bits;

    timer_state_e     cur_state, nxt_state;
    logic [PRE_W-1:0] presc, nxt_presc;
    logic             tick, tick_nxt;
    logic             clr_q;
    logic             run_q;
    logic             done_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (bus.key_n[KEY_START]),
        .key_db (key_db[KEY_START]),
        .press  (press[KEY_START])
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (bus.key_n[KEY_CLEAR]),
        .key_db (key_db[KEY_CLEAR]),
        .press  (press[KEY_CLEAR])
    );

    assign start_ev = press[KEY_START];

`ifdef TIMER_LONGPRESS_CLR_EN
    localparam int unsigned LP_W = (LP_CYCLES > 1) ? $clog2(LP_CYCLES) : 1;

    logic [LP_W-1:0] lp_cnt;
    logic            lp_fired;

    // Hold-time counter; fires once per hold and rearms when the key is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt   <= '0;
            lp_fired <= 1'b0;
        end else if (key_db[KEY_CLEAR]) begin
            lp_cnt   <= '0;
            lp_fired <= 1'b0;
        end else if (!lp_fired) begin
            if (lp_cnt == LP_W'(LP_CYCLES - 1)) begin
                lp_cnt   <= '0;
                lp_fired <= 1'b1;
            end else begin
                lp_cnt <= lp_cnt + LP_W'(1);
            end
        end
    end

    assign clr_ev      = ~key_db[KEY_CLEAR] & ~lp_fired & (lp_cnt == LP_W'(LP_CYCLES - 1));
    assign unused_bits = ^{press[KEY_CLEAR], key_db[KEY_START]};
`else
    assign clr_ev      = press[KEY_CLEAR];
    // Hold time and stable key levels have no consumer without the long-press option.
    assign unused_bits = ^{key_db, LP_CYCLES};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            presc     <= '0;
            tick      <= 1'b0;
            clr_q     <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            presc     <= nxt_presc;
            tick      <= tick_nxt;
            clr_q     <= clr_ev;
            run_q     <= (nxt_state == RUN);
            done_q    <= (nxt_state == DONE);
        end
    end

    // Clear beats everything; the prescaler only advances while running.
    always_comb begin
        nxt_state = cur_state;
        nxt_presc = presc;
        tick_nxt  = 1'b0;
        if (clr_ev) begin
            nxt_state = IDLE;
            nxt_presc = '0;
        end else begin
            unique case (cur_state)
                IDLE:    if (start_ev) nxt_state = RUN;
                RUN: begin
                    if (bus.timeup)    nxt_state = DONE;
                    else if (start_ev) nxt_state = PAUSE;
                end
                PAUSE:   if (start_ev) nxt_state = RUN;
                DONE:    nxt_state = DONE;
                default: nxt_state = IDLE;
            endcase
            if (cur_state == RUN) begin
                if (presc == PRE_W'(SEC_CYCLES - 1)) begin
                    nxt_presc = '0;
                    tick_nxt  = ~bus.timeup;
                end else begin
                    nxt_presc = presc + PRE_W'(1);
                end
            end
        end
    end

    assign bus.state     = cur_state;
    assign bus.tick_1s   = tick;
    assign bus.clr_pulse = clr_q;
    assign bus.run       = run_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Directed bench for timer_key_ctrl at 1 kHz: DB=4, SEC=1000, LP=20 cycles.
// Also covers the TIMER_LONGPRESS_CLR_EN build when that macro is defined.
module tb_timer_key_ctrl;
    import timer_pkg::*;

`ifdef TIMER_LONGPRESS_CLR_EN
    localparam int CLR_LAT = 26;
`else
    localparam int CLR_LAT = 8;
`endif
    localparam int NVEC = 18;

    typedef struct {
        logic [1:0]   key;
        logic         tu;
        int           len;
        timer_state_e st;
        int           clr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks    = 0;
    int   n_err       = 0;
    int   tick_cnt    = 0;
    int   clr_cnt     = 0;
    int   overlap_cnt = 0;
    vec_t vecs [NVEC];

    timer_key_ctrl_if bus ();

    timer_key_ctrl #(
        .CLK_FREQ_KHZ (1),
        .DEBOUNCE_MS  (4),
        .LONGPRESS_MS (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tick_1s) tick_cnt++;
        if (bus.clr_pulse) clr_cnt++;
        if (bus.tick_1s && bus.clr_pulse) overlap_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input timer_state_e st);
        check({name, ".state"}, int'(bus.state), int'(st));
        check({name, ".run"}, int'(bus.run), int'(st == RUN));
        check({name, ".done"}, int'(bus.done), int'(st == DONE));
    endtask

    task automatic wait_tick(input string name, input int exp);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.tick_1s && n < exp + 100);
        check(name, n, exp);
    endtask

    task automatic press_clear(input string name, input logic [1:0] k);
        int c0 = clr_cnt;
        bus.key_n = k;
        step(CLR_LAT - 1);
        check({name, ".early"}, int'(bus.clr_pulse), 0);
        step(1);
        check({name, ".pulse"}, int'(bus.clr_pulse), 1);
        check_state(name, IDLE);
        step(1);
        check({name, ".width"}, int'(bus.clr_pulse), 0);
        bus.key_n = 2'b11;
        step(20);
        check({name, ".count"}, clr_cnt - c0, 1);
    endtask

    initial begin
        int c0;
        vecs[0]  = '{2'b01, 1'b0, 40, IDLE,  1};
        vecs[1]  = '{2'b11, 1'b0, 20, IDLE,  0};
        vecs[2]  = '{2'b10, 1'b1,  7, IDLE,  0};
        vecs[3]  = '{2'b10, 1'b0,  1, RUN,   0};
        vecs[4]  = '{2'b11, 1'b0, 20, RUN,   0};
        vecs[5]  = '{2'b10, 1'b0, 20, PAUSE, 0};
        vecs[6]  = '{2'b11, 1'b1, 20, PAUSE, 0};
        vecs[7]  = '{2'b10, 1'b0, 20, RUN,   0};
        vecs[8]  = '{2'b11, 1'b1,  3, DONE,  0};
        vecs[9]  = '{2'b11, 1'b0, 10, DONE,  0};
        vecs[10] = '{2'b10, 1'b0, 20, DONE,  0};
        vecs[11] = '{2'b11, 1'b0, 20, DONE,  0};
        vecs[12] = '{2'b01, 1'b0, 40, IDLE,  1};
        vecs[13] = '{2'b11, 1'b0, 20, IDLE,  0};
        vecs[14] = '{2'b10, 1'b0, 20, RUN,   0};
        vecs[15] = '{2'b11, 1'b0, 20, RUN,   0};
        vecs[16] = '{2'b00, 1'b0, 40, IDLE,  1};
        vecs[17] = '{2'b11, 1'b0, 20, IDLE,  0};

        bus.key_n  = 2'b11;
        bus.timeup = 1'b0;
        step(3);
        check_state("reset", IDLE);
        check("reset.tick", int'(bus.tick_1s), 0);
        check("reset.clr", int'(bus.clr_pulse), 0);
        rst_n = 1'b1;
        step(10);
        check("release.clr_cnt", clr_cnt, 0);
        check("release.tick_cnt", tick_cnt, 0);

        // Two 3-cycle lows separated by 2-cycle highs must be rejected
        for (int i = 0; i < 2; i++) begin
            bus.key_n = 2'b10;
            step(3);
            bus.key_n = 2'b11;
            step(2);
        end
        step(20);
        check_state("bounce", IDLE);

        // A 4-cycle low is the shortest accepted press
        bus.key_n = 2'b10;
        step(4);
        bus.key_n = 2'b11;
        step(3);
        check_state("db_min.c7", IDLE);
        step(1);
        check_state("db_min.c8", RUN);
        step(20);
        press_clear("clr_run", 2'b01);

        // Start with the key held; ticks every 1000 cycles
        bus.key_n = 2'b10;
        step(7);
        check_state("start.c7", IDLE);
        step(1);
        check_state("start.c8", RUN);
        for (int i = 0; i < 3; i++) wait_tick($sformatf("start.tick%0d", i), 1000);
        check_state("start.held", RUN);

        // Pause with 300 cycles of phase, resume, 700 more to the tick
        bus.key_n = 2'b11;
        step(292);
        check("start.tick_cnt", tick_cnt, 3);
        bus.key_n = 2'b10;
        step(8);
        check_state("pause.enter", PAUSE);
        bus.key_n = 2'b11;
        step(150);
        check_state("pause.hold", PAUSE);
        check("pause.no_tick", tick_cnt, 3);
        bus.key_n = 2'b10;
        step(8);
        check_state("resume", RUN);
        wait_tick("resume.tick", 700);

        // timeup on the cycle the prescaler is at its last count
        step(999);
        bus.timeup = 1'b1;
        step(1);
        check_state("timeup", DONE);
        check("timeup.no_tick", int'(bus.tick_1s), 0);
        bus.timeup = 1'b0;
        bus.key_n  = 2'b11;
        step(20);
        bus.key_n = 2'b10;
        step(20);
        check_state("done.start", DONE);
        bus.key_n = 2'b11;
        step(20);
        check("done.tick_cnt", tick_cnt, 4);

        for (int i = 0; i < NVEC; i++) begin
            c0         = clr_cnt;
            bus.key_n  = vecs[i].key;
            bus.timeup = vecs[i].tu;
            step(vecs[i].len);
            check_state($sformatf("vec%0d", i), vecs[i].st);
            check($sformatf("vec%0d.clr", i), clr_cnt - c0, vecs[i].clr);
        end
        bus.timeup = 1'b0;

        // Both keys in RUN: clear wins and the prescaler restarts from zero
        bus.key_n = 2'b10;
        step(8);
        check_state("prio.run", RUN);
        bus.key_n = 2'b11;
        step(92);
        press_clear("prio.both", 2'b00);
        bus.key_n = 2'b10;
        step(8);
        check_state("prio.restart", RUN);
        wait_tick("prio.first_tick", 1000);
        bus.key_n = 2'b11;
        step(20);

`ifdef TIMER_LONGPRESS_CLR_EN
        c0        = clr_cnt;
        bus.key_n = 2'b01;
        step(10);
        bus.key_n = 2'b11;
        step(40);
        check("lp.short", clr_cnt - c0, 0);
        check_state("lp.short", RUN);
        c0        = clr_cnt;
        bus.key_n = 2'b01;
        step(25);
        check("lp.early", int'(bus.clr_pulse), 0);
        step(1);
        check("lp.pulse", int'(bus.clr_pulse), 1);
        step(14);
        bus.key_n = 2'b11;
        step(20);
        check("lp.once", clr_cnt - c0, 1);
        check_state("lp.hold", IDLE);
`else
        c0        = clr_cnt;
        bus.key_n = 2'b01;
        step(10);
        bus.key_n = 2'b11;
        step(20);
        check("short_clr", clr_cnt - c0, 1);
        check_state("short_clr", IDLE);
`endif

        // Asynchronous reset in the middle of a run
        bus.key_n = 2'b10;
        step(8);
        check_state("rst_mid.run", RUN);
        bus.key_n = 2'b11;
        step(10);
        rst_n = 1'b0;
        #1;
        check_state("rst_mid", IDLE);
        check("rst_mid.tick", int'(bus.tick_1s), 0);
        c0 = clr_cnt;
        step(3);
        rst_n = 1'b1;
        step(20);
        check("rst_mid.no_clr", clr_cnt - c0, 0);
        check_state("rst_mid.after", IDLE);

        check("tick_clr_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_key_ctrl.md
Name: timer_key_ctrl

Overview:
- Upstream control stage for the ramen timer. It conditions the two active-low push buttons KEY[1:0] and runs the start/pause/clear state machine.
- It generates the gated 1 s tick and the clear pulse that drive the seconds counter, the time-limit counter and the digit decoder chain.
- It replaces the free-running seconds strobe. Counting advances only while the timer is running.

Parameters:
- CLK_FREQ_KHZ, 50000, input clock frequency in kHz. SEC_CYCLES = CLK_FREQ_KHZ*1000.
- DEBOUNCE_MS, 10, stable time required before a key change is accepted. DB_CYCLES = CLK_FREQ_KHZ*DEBOUNCE_MS.
- LONGPRESS_MS, 2000, hold time for long-press clear (optional feature only). LP_CYCLES = CLK_FREQ_KHZ*LONGPRESS_MS.

Ports:
- clk  in  1  system clock (CLK_50M domain).
- rst_n  in  1  reset, asynchronous, active-low.
- key_n  in  2  raw asynchronous buttons, 0 = pressed. Bit 0 = start/pause, bit 1 = clear.
- timeup  in  1  level from the time-limit counter; limit reached.
- tick_1s  out  1  single-cycle pulse once per SEC_CYCLES cycles spent in RUN.
- clr_pulse  out  1  single-cycle pulse that clears all downstream counters.
- run  out  1  high while state == RUN.
- done  out  1  high while state == DONE.
- state  out  2  current FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3).

Behaviour:
- Reset (async assert, sync use): sync FFs = 1, debounced keys = 1, counters = 0, state = IDLE, all outputs 0.
- Synchroniser: 2-FF per key, reset value 1 (released).
- Debounce, per key:
  - db_cnt increments while the synced value differs from the stable value key_db.
  - db_cnt clears to 0 whenever they are equal, so a bounce restarts the count.
  - When db_cnt == DB_CYCLES-1 and they still differ: key_db takes the synced value and db_cnt returns to 0.
- Press event: registered falling edge of key_db, one cycle wide.
  - Latency from a clean input edge to the press pulse is exactly 2 + DB_CYCLES + 1 cycles.
  - Release produces no event.
- FSM transitions (clear has the highest priority in every state):
  - any state, clear event -> IDLE; clr_pulse = 1 on the next cycle.
  - IDLE: start event -> RUN; timeup ignored.
  - RUN: timeup -> DONE (wins over start); else start event -> PAUSE.
  - PAUSE: start event -> RUN; timeup ignored.
  - DONE: start event ignored; exit only via clear.
- Prescaler:
  - Width $clog2(SEC_CYCLES). Increments only in RUN and wraps SEC_CYCLES-1 -> 0.
  - Holds its value in PAUSE and DONE, so pause/resume preserves the sub-second phase.
  - Forced to 0 on a clear event.
- tick_1s: registered, asserted the cycle after prescaler == SEC_CYCLES-1 while in RUN.
  - Suppressed if timeup or a clear event occurs in that same cycle.
  - Never asserted in the cycle that clr_pulse is high.
- First tick after IDLE->RUN arrives exactly SEC_CYCLES cycles after state first reads RUN.
- Reset mid-operation: everything returns to reset values immediately. No tick or clear pulse is generated on reset release.
- Both keys pressed together: clear wins and start is dropped. A held start key produces no further events.

Optional Feature:
- Macro TIMER_LONGPRESS_CLR_EN.
- Defined:
  - A clear event fires only after key_db[1] has been low for LP_CYCLES consecutive cycles.
  - One event per hold; rearms only after release.
  - A short press of key 1 does nothing.
- Undefined: a clear event fires on every key 1 press event. No long-press counter is synthesised.

Decomposition:
- Package timer_pkg holds:
  - typedef enum logic [1:0] timer_state_e {IDLE, RUN, PAUSE, DONE};
  - function cycles_from_ms(freq_khz, ms);
  - KEY_START=0 and KEY_CLEAR=1 index constants.
- Sub-module key_debounce: sync + debounce + press-edge for one key, parameterised by DB_CYCLES, instantiated twice.

Test Plan (CLK_FREQ_KHZ=1, DEBOUNCE_MS=4, LONGPRESS_MS=20 -> DB=4, SEC=1000, LP=20 cycles):
- Bounce rejection: key_n[0] low for 3 cycles, high 2, low 3, high -> no press event, state stays IDLE.
- Start: key_n[0] low and held from cycle 0 -> state=RUN at cycle 8. tick_1s pulses at cycles 1008, 2008, 3008.
- Pause/resume: press start 300 cycles after RUN -> PAUSE with the tick withheld. Resume -> first tick 700 cycles after re-entering RUN.
- Timeup: in RUN, assert timeup on the same cycle the prescaler hits 999 -> state=DONE, no tick. A subsequent start press leaves state=DONE.
- Clear priority: key_n[1:0]=00 pressed together in RUN -> state=IDLE, one clr_pulse, prescaler=0, run=0.
- With TIMER_LONGPRESS_CLR_EN: 10-cycle key 1 press -> no clear. Hold 40 cycles -> exactly one clr_pulse, 20 cycles after key_db falls.
